// File: rtl/led_scan_mux.sv
// led_scan_mux: time-multiplexes four 7-segment vectors onto one bus.
// Blanking between digits, frame-coherent capture, leading-zero blanking.
module led_scan_mux #(
    parameter int DIGIT_CYCLES  = 250,
    parameter int DEAD_CYCLES   = 4,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       EN,
    input  logic       LED_TYPE,
    input  logic       ZS,
    input  logic [6:0] LED1,
    input  logic [6:0] LED2,
    input  logic [6:0] LED3,
    input  logic [6:0] LED4,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic [1:0] DIGIT_IDX,
    output logic       FRAME_DONE
);

    localparam int CMAX = (DIGIT_CYCLES > DEAD_CYCLES) ?
                          DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] ZERO = 7'b1111110;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state, state_nx;
    logic [1:0]      idx, idx_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [6:0]      seg_on, seg_nx;
    logic [3:0]      an_r, an_nx;
    logic            fd, fd_nx;
    logic [6:0]      shadow [4];
    logic [6:0]      shadow_nx [4];
    logic [6:0]      norm [4];
    logic [6:0]      disp [4];
    logic [3:0]      zero;
    logic [3:0]      blank;
    logic [3:0]      onehot;
    logic [3:0]      an_sel;
    logic            capture;

    // Normalise inputs, capture bypass, zero suppression and digit select.
    always_comb begin
        norm[0] = LED_TYPE ? LED1 : ~LED1;
        norm[1] = LED_TYPE ? LED2 : ~LED2;
        norm[2] = LED_TYPE ? LED3 : ~LED3;
        norm[3] = LED_TYPE ? LED4 : ~LED4;
        capture = (state == BLANK) && (idx == 2'd0);
        for (int i = 0; i < 4; i++) begin
            shadow_nx[i] = capture ? norm[i] : shadow[i];
            zero[i]      = (shadow_nx[i] == ZERO);
        end
        blank[0] = 1'b0;
        blank[3] = zero[3];
        blank[2] = zero[3] & zero[2];
        blank[1] = zero[3] & zero[2] & zero[1];
        for (int i = 0; i < 4; i++) begin
            disp[i] = (ZS && blank[i]) ? 7'd0 : shadow_nx[i];
        end
        onehot = 4'b0001 << idx;
        an_sel = AN_ACTIVE_LOW ? ~onehot : onehot;
    end

    // Next-state and registered-output logic for the scan FSM.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        seg_nx   = seg_on;
        an_nx    = an_r;
        fd_nx    = 1'b0;
        if (!EN) begin
            state_nx = BLANK;
            idx_nx   = 2'd0;
            cnt_nx   = '0;
            seg_nx   = 7'd0;
            an_nx    = AN_OFF;
        end else begin
            unique case (state)
                BLANK: begin
                    an_nx  = AN_OFF;
                    seg_nx = 7'd0;
                    if (cnt == CW'(DEAD_CYCLES - 1)) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                        an_nx    = an_sel;
                        seg_nx   = disp[idx];
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == CW'(DIGIT_CYCLES - 1)) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        idx_nx   = idx + 2'd1;
                        an_nx    = AN_OFF;
                        seg_nx   = 7'd0;
                        fd_nx    = (idx == 2'd3);
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = BLANK;
            endcase
        end
    end

    // State, counters, outputs and shadow registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= BLANK;
            idx    <= 2'd0;
            cnt    <= '0;
            seg_on <= 7'd0;
            an_r   <= AN_OFF;
            fd     <= 1'b0;
            for (int i = 0; i < 4; i++) shadow[i] <= 7'd0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            cnt    <= cnt_nx;
            seg_on <= seg_nx;
            an_r   <= an_nx;
            fd     <= fd_nx;
            for (int i = 0; i < 4; i++) shadow[i] <= shadow_nx[i];
        end
    end

    assign SEG        = LED_TYPE ? seg_on : ~seg_on;
    assign AN         = an_r;
    assign DIGIT_IDX  = idx;
    assign FRAME_DONE = fd;

endmodule

// File: tb/tb_led_scan_mux.sv
// tb_led_scan_mux: directed checks of scan timing, capture,
// zero suppression, polarity, enable and asynchronous reset.
module tb_led_scan_mux;

    typedef logic [6:0] dig4_t [4];

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       EN = 1'b0;
    logic       LED_TYPE = 1'b1;
    logic       ZS = 1'b0;
    logic [6:0] LED1 = '0, LED2 = '0, LED3 = '0, LED4 = '0;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic [1:0] DIGIT_IDX;
    logic       FRAME_DONE;

    int errors = 0;
    int checks = 0;

    led_scan_mux #(
        .DIGIT_CYCLES(4),
        .DEAD_CYCLES(1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .EN(EN),
        .LED_TYPE(LED_TYPE), .ZS(ZS),
        .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4),
        .SEG(SEG), .AN(AN), .DIGIT_IDX(DIGIT_IDX),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 clk = ~clk;

    // Expected outputs after the k-th edge since restart (k>=1).
    task automatic expect_at(input int k, input dig4_t d,
                             input logic lt,
                             output logic [3:0] an,
                             output logic [6:0] seg,
                             output logic fd,
                             output logic [1:0] ix);
        int p, dg, s;
        logic [6:0] sn;
        p = (k - 1) % 20;
        dg = p / 5;
        s = p % 5;
        if (s < 4) begin
            an = ~(4'b0001 << dg);
            sn = d[dg];
            ix = 2'(dg);
        end else begin
            an = 4'hF;
            sn = 7'd0;
            ix = 2'((dg + 1) % 4);
        end
        seg = lt ? sn : ~sn;
        fd = (k % 20 == 0);
    endtask

    task automatic restart(input logic lt, input logic zs,
                           input logic [6:0] l1, input logic [6:0] l2,
                           input logic [6:0] l3, input logic [6:0] l4);
        @(negedge clk);
        resetn = 1'b0;
        EN = 1'b1;
        LED_TYPE = lt;
        ZS = zs;
        LED1 = l1; LED2 = l2; LED3 = l3; LED4 = l4;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic scan_check(input string nm, input int n,
                              input dig4_t d, input logic lt);
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        logic [1:0] ei;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            expect_at(k, d, lt, ea, es, ef, ei);
            checks++;
            if (AN !== ea || SEG !== es ||
                FRAME_DONE !== ef || DIGIT_IDX !== ei) begin
                errors++;
                $display("FAIL %s k=%0d AN=%h SEG=%b FD=%b IDX=%0d want AN=%h SEG=%b FD=%b IDX=%0d",
                         nm, k, AN, SEG, FRAME_DONE, DIGIT_IDX,
                         ea, es, ef, ei);
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        EN = 1'b1;
        LED_TYPE = 1'b1;
        #12;
        checks++;
        if (AN !== 4'hF || SEG !== 7'd0 ||
            DIGIT_IDX !== 2'd0 || FRAME_DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset AN=%h SEG=%b IDX=%0d FD=%b want F/0/0/0",
                     AN, SEG, DIGIT_IDX, FRAME_DONE);
        end
    endtask

    task automatic test_scan;
        restart(1'b1, 1'b0, S1, S2, S3, S4);
        scan_check("scan", 40, '{S1, S2, S3, S4}, 1'b1);
    endtask

    task automatic test_zero_suppress;
        restart(1'b1, 1'b1, S5, S0, S0, S0);
        scan_check("zs_on", 20, '{S5, 7'd0, 7'd0, 7'd0}, 1'b1);
        restart(1'b1, 1'b0, S5, S0, S0, S0);
        scan_check("zs_off", 20, '{S5, S0, S0, S0}, 1'b1);
        restart(1'b1, 1'b1, S0, S0, S1, S0);
        scan_check("zs_mid", 20, '{S0, S0, S1, 7'd0}, 1'b1);
    endtask

    task automatic test_led_type;
        restart(1'b0, 1'b0, ~S1, ~S2, ~S3, ~S4);
        scan_check("active_low", 20, '{S1, S2, S3, S4}, 1'b0);
    endtask

    task automatic test_frame_capture;
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        logic [1:0] ei;
        dig4_t d;
        restart(1'b1, 1'b0, S1, S2, S3, S4);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            d = (k <= 20) ? '{S1, S2, S3, S4} : '{S1, S5, S0, S4};
            expect_at(k, d, 1'b1, ea, es, ef, ei);
            checks++;
            if (AN !== ea || SEG !== es || FRAME_DONE !== ef) begin
                errors++;
                $display("FAIL capture k=%0d AN=%h SEG=%b FD=%b want AN=%h SEG=%b FD=%b",
                         k, AN, SEG, FRAME_DONE, ea, es, ef);
            end
            if (k == 7) begin
                LED2 = S5;
                LED3 = S0;
            end
        end
    endtask

    task automatic test_enable_reset;
        restart(1'b1, 1'b0, S1, S2, S3, S4);
        scan_check("pre_en", 2, '{S1, S2, S3, S4}, 1'b1);
        EN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (AN !== 4'hF || SEG !== 7'd0 ||
                DIGIT_IDX !== 2'd0 || FRAME_DONE !== 1'b0) begin
                errors++;
                $display("FAIL en_low k=%0d AN=%h SEG=%b IDX=%0d want F/0/0",
                         k, AN, SEG, DIGIT_IDX);
            end
        end
        EN = 1'b1;
        scan_check("en_restart", 7, '{S1, S2, S3, S4}, 1'b1);
        resetn = 1'b0;
        #1;
        checks++;
        if (AN !== 4'hF || SEG !== 7'd0 ||
            DIGIT_IDX !== 2'd0 || FRAME_DONE !== 1'b0) begin
            errors++;
            $display("FAIL async_rst AN=%h SEG=%b IDX=%0d want F/0/0",
                     AN, SEG, DIGIT_IDX);
        end
        @(negedge clk);
        resetn = 1'b1;
        scan_check("rst_restart", 20, '{S1, S2, S3, S4}, 1'b1);
    endtask

    initial begin
        test_reset;
        test_scan;
        test_zero_suppress;
        test_led_type;
        test_frame_capture;
        test_enable_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
